button_debounce_multi: RTL and testbench

Parametrised N-channel push-button conditioner, successor to the single-button debouncer. Per channel it does the following:
- synchronises the raw pin;
- accepts a level change only after it has been stable for DEB_CYCLES clocks;
- emits one-cycle press/release pulses;
- adds long-press detection and optional auto-repeat.

It sits between board button pins and user-interface logic, all in the system clock domain.

---
 rtl/btn_pkg.sv | 26 ++
 rtl/button_debounce_multi_channel.sv | 124 ++++++++++++
 rtl/button_debounce_multi.sv | 56 +++++
 tb/tb_button_debounce_multi.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the multi-channel button conditioner.
// Counter-width helper, idle pin level helper and per-channel output bundle.
package btn_pkg;

  localparam bit ACTIVE_LOW_DEF = 1'b1;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  // Level a released (idle) pin reads.
  function automatic logic idle_lvl(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  typedef struct packed {
    logic lvl;
    logic press;
    logic rel;
    logic lng;
    logic rpt;
  } ch_out_t;

endpackage

// File: rtl/button_debounce_multi_channel.sv
// One button channel: 2-flop synchroniser, debounce, edge pulses, long/repeat.
// Ports: clk, rst_n, btn_i (raw pin), rep_en_i, out_o (ch_out_t bundle).
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES    = 200000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    btn_i,
  input  logic    rep_en_i,
  output ch_out_t out_o
);

  localparam logic IDLE   = idle_lvl(ACTIVE_LOW != 0);
  localparam int   DW     = cnt_w(DEB_CYCLES);
  localparam int   HW     = cnt_w(LONG_CYCLES + 1);
  localparam bit   REP_ON = (REPEAT_CYCLES > 0);
  localparam int   REP_N  = REP_ON ? REPEAT_CYCLES : 1;
  localparam int   RW     = cnt_w(REP_N);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REP_N - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          lvl_q, lvl_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          lng_q, lng_d;
  logic          rpt_q, rpt_d;
  logic          arm_q, arm_d;

  logic p;
  logic differ;
  logic hit;
  logic rep_act;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;

    p      = sync2_q ^ IDLE;
    differ = (p != lvl_q);
    hit    = differ && (deb_q == DEB_LAST);

    // Any agreement with the accepted level restarts the count.
    deb_d = '0;
    if (differ && !hit) deb_d = deb_q + DW'(1);

    lvl_d   = hit ? p : lvl_q;
    press_d = hit && p;
    rel_d   = hit && !p;

    hold_d = '0;
    if (lvl_q) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
    end

    lng_d = lvl_q && !rel_d && (hold_q == HOLD_LAST);

    // Repeat phase begins with the long pulse and ends on release.
    arm_d = arm_q;
    if (!lvl_q || rel_d) arm_d = 1'b0;
    else if (lng_d)      arm_d = 1'b1;

    rep_act = REP_ON && arm_q && rep_en_i && lvl_q && !rel_d;

    rep_d = '0;
    rpt_d = 1'b0;
    if (rep_act) begin
      if (rep_q == REP_LAST) begin
        rpt_d = 1'b1;
      end else begin
        rep_d = rep_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
      deb_q   <= '0;
      hold_q  <= '0;
      rep_q   <= '0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      lng_q   <= 1'b0;
      rpt_q   <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      lng_q   <= lng_d;
      rpt_q   <= rpt_d;
      arm_q   <= arm_d;
    end
  end

  always_comb begin
    out_o.lvl   = lvl_q;
    out_o.press = press_q;
    out_o.rel   = rel_q;
    out_o.lng   = lng_q;
    out_o.rpt   = rpt_q;
  end

endmodule

// File: rtl/button_debounce_multi.sv
// N-channel push-button conditioner: one debounce_channel per pin.
// Ports: clock, async reset, pins, repeat enables; level/press/release/long/repeat.
module button_debounce_multi
  import btn_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DEB_CYCLES    = 200000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int ACTIVE_LOW    = int'(ACTIVE_LOW_DEF)
) (
  input  logic              i_Clock50MHz,
  input  logic              i_Rst_n,
  input  logic [NUM_CH-1:0] i_Btn,
  input  logic [NUM_CH-1:0] i_Repeat_En,
  output logic [NUM_CH-1:0] o_Level,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic [NUM_CH-1:0] o_Long,
  output logic [NUM_CH-1:0] o_Repeat
);

  if (DEB_CYCLES < 2) begin : g_err_deb
    $error("DEB_CYCLES must be >= 2");
  end
  if (LONG_CYCLES <= DEB_CYCLES) begin : g_err_long
    $error("LONG_CYCLES must exceed DEB_CYCLES");
  end
  if (NUM_CH < 1 || NUM_CH > 32) begin : g_err_nch
    $error("NUM_CH must be in 1..32");
  end

  ch_out_t ch_out [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEB_CYCLES    (DEB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk      (i_Clock50MHz),
      .rst_n    (i_Rst_n),
      .btn_i    (i_Btn[g]),
      .rep_en_i (i_Repeat_En[g]),
      .out_o    (ch_out[g])
    );

    assign o_Level[g]   = ch_out[g].lvl;
    assign o_Press[g]   = ch_out[g].press;
    assign o_Release[g] = ch_out[g].rel;
    assign o_Long[g]    = ch_out[g].lng;
    assign o_Repeat[g]  = ch_out[g].rpt;
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed scoreboard bench for button_debounce_multi.
// Expected pulses are queued by cycle and checked every cycle.
module tb_button_debounce_multi;

  localparam int NCH = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] btn = 2'b11;
  logic [NCH-1:0] ren = 2'b00;
  logic [NCH-1:0] o_Level, o_Press, o_Release, o_Long, o_Repeat;

  always #5 clk = ~clk;

  button_debounce_multi #(
    .NUM_CH        (NCH),
    .DEB_CYCLES    (8),
    .LONG_CYCLES   (32),
    .REPEAT_CYCLES (8),
    .ACTIVE_LOW    (1)
  ) dut (
    .i_Clock50MHz (clk),
    .i_Rst_n      (rst_n),
    .i_Btn        (btn),
    .i_Repeat_En  (ren),
    .o_Level      (o_Level),
    .o_Press      (o_Press),
    .o_Release    (o_Release),
    .o_Long       (o_Long),
    .o_Repeat     (o_Repeat)
  );

  typedef struct {
    int         cyc;
    logic [7:0] pul;
  } ev_t;

  ev_t            sb [$];
  int             checks = 0;
  int             errors = 0;
  int             edge_n = 0;
  logic [NCH-1:0] exp_lvl = '0;
  int             c;
  int             pt;

  // pul layout: {rpt, lng, rel, press}
  function automatic logic [7:0] ev(input logic [1:0] pr, input logic [1:0] rl,
                                    input logic [1:0] lg, input logic [1:0] rp);
    return {rp, lg, rl, pr};
  endfunction

  task automatic push(input int at, input logic [7:0] pul);
    ev_t e;
    e.cyc = at;
    e.pul = pul;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h edge=%0d", tag, obs, exp, edge_n);
    end
  endtask

  task automatic tick();
    logic [7:0] e;
    e = '0;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edge_n) begin
        e |= sb[i].pul;
        sb.delete(i);
      end
    end
    exp_lvl = (exp_lvl | e[1:0]) & ~e[3:2];
    cmp("pulses", 32'({o_Repeat, o_Long, o_Release, o_Press}), 32'(e));
    cmp("level", 32'(o_Level), 32'(exp_lvl));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) tick();
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_lvl = '0;
    cmp(tag, 32'({o_Level, o_Press, o_Release, o_Long, o_Repeat}), 32'd0);
  endtask

  initial begin
    // Reset state
    run(3);
    cmp("reset_outs", 32'({o_Level, o_Press, o_Release, o_Long, o_Repeat}), 32'd0);
    rst_n = 1'b1;
    run(2);

    // 1. Clean press then release, ch1 idle
    c = edge_n;
    btn[0] = 1'b0;
    push(c + 10, ev(2'b01, 2'b00, 2'b00, 2'b00));
    run(12);
    c = edge_n;
    btn[0] = 1'b1;
    push(c + 10, ev(2'b00, 2'b01, 2'b00, 2'b00));
    run(12);

    // 2. Bounce: low 5, high 1, low steady
    btn[0] = 1'b0;
    run(5);
    btn[0] = 1'b1;
    run(1);
    c = edge_n;
    btn[0] = 1'b0;
    push(c + 10, ev(2'b01, 2'b00, 2'b00, 2'b00));
    run(12);
    c = edge_n;
    btn[0] = 1'b1;
    push(c + 10, ev(2'b00, 2'b01, 2'b00, 2'b00));
    run(12);
    // 7-cycle glitch: no pulse
    btn[0] = 1'b0;
    run(7);
    btn[0] = 1'b1;
    run(15);

    // 3. Long press with repeat; release lands on a would-be repeat cycle
    ren[0] = 1'b1;
    c = edge_n;
    pt = c + 10;
    btn[0] = 1'b0;
    push(pt,      ev(2'b01, 2'b00, 2'b00, 2'b00));
    push(pt + 32, ev(2'b00, 2'b00, 2'b01, 2'b00));
    push(pt + 40, ev(2'b00, 2'b00, 2'b00, 2'b01));
    push(pt + 48, ev(2'b00, 2'b00, 2'b00, 2'b01));
    push(pt + 56, ev(2'b00, 2'b00, 2'b00, 2'b01));
    run_to(pt + 54);
    btn[0] = 1'b1;
    push(pt + 64, ev(2'b00, 2'b01, 2'b00, 2'b00));
    run(22);

    // 4. Repeat disabled: long once, no repeat
    ren[0] = 1'b0;
    c = edge_n;
    pt = c + 10;
    btn[0] = 1'b0;
    push(pt,      ev(2'b01, 2'b00, 2'b00, 2'b00));
    push(pt + 32, ev(2'b00, 2'b00, 2'b01, 2'b00));
    run_to(pt + 45);
    btn[0] = 1'b1;
    push(pt + 55, ev(2'b00, 2'b01, 2'b00, 2'b00));
    run(15);
    // Released at +20: no long
    c = edge_n;
    pt = c + 10;
    btn[0] = 1'b0;
    push(pt, ev(2'b01, 2'b00, 2'b00, 2'b00));
    run_to(pt + 10);
    btn[0] = 1'b1;
    push(pt + 20, ev(2'b00, 2'b01, 2'b00, 2'b00));
    run(40);

    // 5. Simultaneous press, staggered release
    c = edge_n;
    btn = 2'b00;
    push(c + 10, ev(2'b11, 2'b00, 2'b00, 2'b00));
    run(14);
    c = edge_n;
    btn[0] = 1'b1;
    push(c + 10, ev(2'b00, 2'b01, 2'b00, 2'b00));
    run(3);
    c = edge_n;
    btn[1] = 1'b1;
    push(c + 10, ev(2'b00, 2'b10, 2'b00, 2'b00));
    run(15);

    // 6a. Reset during debounce count, pin held low through release
    btn[0] = 1'b0;
    run(5);
    async_reset("rst_deb_async");
    run(3);
    rst_n = 1'b1;
    c = edge_n;
    pt = c + 10;
    push(pt,      ev(2'b01, 2'b00, 2'b00, 2'b00));
    push(pt + 32, ev(2'b00, 2'b00, 2'b01, 2'b00));
    push(pt + 40, ev(2'b00, 2'b00, 2'b00, 2'b01));
    ren[0] = 1'b1;
    // 6b. Reset during repeat phase, pin released while in reset
    run_to(pt + 43);
    async_reset("rst_rep_async");
    run(3);
    btn = 2'b11;
    rst_n = 1'b1;
    run(20);

    cmp("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
